// File: rtl/code_entry_fsm_if.sv
// code_entry_fsm_if: key strobe in, lock status out between keypad decoder and code entry controller.
interface code_entry_fsm_if;
  logic [3:0] digit;
  logic       valid;
  logic       unlocked;
  logic       programming;
  logic       alarm;
  logic       error;
  logic [2:0] entry_count;
  modport master (output digit, valid, input unlocked, programming, alarm, error, entry_count);
  modport slave (input digit, valid, output unlocked, programming, alarm, error, entry_count);
endinterface

// File: rtl/code_entry_fsm.sv
// code_entry_fsm: passcode entry with unlock, reprogramming and timed lockout after repeated failures.
module code_entry_fsm #(
  parameter int CODE_LEN = 4,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input logic clk,
  input logic reset,
  code_entry_fsm_if.slave bus
);
  localparam int W = 4 * CODE_LEN;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam logic [2:0] LEN = 3'(CODE_LEN);
  localparam logic [FW-1:0] FLAST = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0] TLAST = TW'(LOCKOUT_CYCLES - 1);
  typedef enum logic [1:0] {ENTRY, UNLOCKED, PROGRAM, LOCKOUT} state_t;
  state_t state;
  logic [W-1:0] buffer, stored_code;
  logic [2:0] count;
  logic [FW-1:0] fail_count;
  logic [TW-1:0] lock_timer;
  logic key_a, key_c, key_e, full, take;
  assign key_a = bus.valid && bus.digit == 4'hA;
  assign key_c = bus.valid && bus.digit == 4'hC;
  assign key_e = bus.valid && bus.digit == 4'hE;
  assign full = count == LEN;
  assign take = bus.valid && bus.digit <= 4'd9 && !full && (state == ENTRY || state == PROGRAM);
  assign bus.entry_count = count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ENTRY;
      buffer <= '0;
      count <= '0;
      stored_code <= DEFAULT_CODE;
      fail_count <= '0;
      lock_timer <= '0;
      bus.unlocked <= 1'b0;
      bus.programming <= 1'b0;
      bus.alarm <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      bus.error <= 1'b0;
      if (take) begin
        buffer <= W'({buffer, bus.digit});
        count <= count + 3'd1;
      end
      case (state)
        ENTRY:
          if (key_c) begin
            buffer <= '0;
            count <= '0;
          end else if (key_a) begin
            buffer <= '0;
            count <= '0;
            if (full && buffer == stored_code) begin
              state <= UNLOCKED;
              bus.unlocked <= 1'b1;
              fail_count <= '0;
            end else if (fail_count == FLAST) begin
              // the final failure locks out silently instead of pulsing error
              state <= LOCKOUT;
              bus.alarm <= 1'b1;
              lock_timer <= '0;
              fail_count <= fail_count + FW'(1);
            end else begin
              bus.error <= 1'b1;
              fail_count <= fail_count + FW'(1);
            end
          end
        UNLOCKED:
          if (key_a || key_e) begin
            buffer <= '0;
            count <= '0;
            state <= key_e ? PROGRAM : ENTRY;
            bus.unlocked <= 1'b0;
            bus.programming <= key_e;
          end
        PROGRAM:
          if (key_c) begin
            buffer <= '0;
            count <= '0;
          end else if (key_a && !full) begin
            bus.error <= 1'b1;
          end else if (key_a || key_e) begin
            if (key_a) stored_code <= buffer;
            buffer <= '0;
            count <= '0;
            state <= UNLOCKED;
            bus.programming <= 1'b0;
            bus.unlocked <= 1'b1;
          end
        LOCKOUT:
          if (lock_timer == TLAST) begin
            state <= ENTRY;
            bus.alarm <= 1'b0;
            fail_count <= '0;
            buffer <= '0;
            count <= '0;
          end else begin
            lock_timer <= lock_timer + TW'(1);
          end
      endcase
    end
endmodule

// File: doc/code_entry_fsm.md
# code_entry_fsm

Passcode entry controller for the security device, directly downstream of the keypad decoder. Consumes one key code per `valid` pulse, collects a fixed-length digit code, compares it against a stored code, and drives unlock, error and alarm indications. Supports relocking, reprogramming the code while unlocked, and a timed lockout after repeated failures.

## Interface

Parameters:
- `CODE_LEN`, 4: digits per code (1..7).
- `MAX_FAILS`, 3: consecutive wrong submissions that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 1000: clock cycles spent in lockout (≥2).
- `DEFAULT_CODE`, 16'h1234: code loaded at reset, 4*CODE_LEN bits, one BCD nibble per digit, first-entered digit in the most significant nibble.

Ports:
- `clk`  input  1  system clock; one clock, all state on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `digit`  input  4  key code: 0–9 digits, 4'hA enter, 4'hC clear, 4'hE program; 4'hB, 4'hD, 4'hF ignored.
- `valid`  input  1  single-cycle strobe; `digit` is sampled only when high.
- `unlocked`  output  1  high while in UNLOCKED.
- `programming`  output  1  high while in PROGRAM.
- `alarm`  output  1  high while in LOCKOUT.
- `error`  output  1  one-cycle pulse on a rejected submission.
- `entry_count`  output  3  digits currently buffered (0..CODE_LEN).

## Operation

- Registers: `buffer` (4*CODE_LEN bits), `count`, `stored_code`, `fail_count` (0..MAX_FAILS), `lock_timer`, `state`.
- Digit entry (ENTRY and PROGRAM): on a digit 0–9 with `count < CODE_LEN`, `buffer <= {buffer[4*CODE_LEN-5:0], digit}` and `count++`. With `count == CODE_LEN`, further digits are ignored.
- States and transitions (all on a `valid` key unless noted):
  - ENTRY (reset state): digits buffer; C clears buffer and count; E ignored. A: if `count == CODE_LEN` and `buffer == stored_code`, go to UNLOCKED and set `fail_count = 0`. Otherwise pulse `error`, clear the buffer, and increment `fail_count`. If the new `fail_count` equals MAX_FAILS, go to LOCKOUT instead and load `lock_timer = 0`.
  - UNLOCKED: digits and C ignored. A clears the buffer and returns to ENTRY (relock). E clears the buffer and goes to PROGRAM.
  - PROGRAM: digits buffer; C clears. A with `count == CODE_LEN` writes `stored_code <= buffer`, clears the buffer and goes to UNLOCKED. A with a short entry pulses `error`, keeps the buffer and stays in PROGRAM. E aborts: clears the buffer, `stored_code` is unchanged, go to UNLOCKED. Does not touch `fail_count`.
  - LOCKOUT: all keys ignored. `lock_timer` increments every cycle. When `lock_timer == LOCKOUT_CYCLES-1`, go to ENTRY with `fail_count = 0` and the buffer cleared.
- Comparison is full-width equality. A short entry never matches, even if its buffered nibbles happen to equal `stored_code`.
- Reset restores `stored_code = DEFAULT_CODE`; a programmed code is not retained across reset.

## Timing

- Reset values: `unlocked=0`, `programming=0`, `alarm=0`, `error=0`, `entry_count=0`, state ENTRY, `fail_count=0`, `lock_timer=0`.
- All outputs are registered. A key sampled at edge N affects outputs visible after edge N (latency 1 cycle).
- `error` is high for exactly the one cycle after the rejecting edge.
- `alarm` is high for exactly LOCKOUT_CYCLES cycles, from the edge that accepts the final failing A.
- `valid` held high for multiple cycles is treated as one key per cycle; no edge detection is done here.
- A `valid` key arriving on the lockout-exit edge is ignored.
- Reset asserted mid-operation, including mid-lockout or mid-PROGRAM, aborts immediately to reset values.

## Test plan

- Reset, enter 1,2,3,4,A -> `unlocked`=1 one cycle after the A edge; `entry_count` steps 1..4 then 0; `fail_count`=0.
- Enter 1,2,3,A -> `error` one-cycle pulse, `unlocked` stays 0, `entry_count`=0. Then 1,2,3,4,5,A -> the 5 is ignored and the entry unlocks.
- With LOCKOUT_CYCLES=8, three wrong 4-digit submissions -> `error` pulses twice, then `alarm`=1 for exactly 8 cycles. Keys 1,2,3,4,A during lockout are ignored. After the alarm drops, the correct code unlocks.
- Unlocked, E, 9,8,7,6,A -> `programming` high during entry, then `unlocked`=1. Then A relocks; 1,2,3,4,A fails; 9,8,7,6,A unlocks.
- In PROGRAM, 5,5,A -> `error` pulse, stay in PROGRAM with `entry_count`=2. Then E -> UNLOCKED with the code unchanged (1234).
- Assert reset mid-lockout, or after programming 9876 -> all outputs 0 immediately; 1,2,3,4,A unlocks.
